// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner
// Description : Synchronise and debounce active-low push-buttons into clean
//               levels, press/release pulses and a one-hot key code.
//               Optional macro KEY_CONDITIONER_LOCKOUT_EN enables first-key lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                        clock,
    input  logic                        n_reset,
    input  logic [NUM_KEYS-1:0]         n_key,
    output logic [NUM_KEYS-1:0]         keyLevel,
    output logic [NUM_KEYS-1:0]         keyPress,
    output logic [NUM_KEYS-1:0]         keyRelease,
    output logic                        anyKey,
    output logic                        keyValid,
    output logic [$clog2(NUM_KEYS)-1:0] keyCode
);

    localparam int c_cnt_w  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_code_w = $clog2(NUM_KEYS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_PEND   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_PEND = 2'd3
    } key_state_t;

    logic [NUM_KEYS-1:0] r_sync1, r_sync2;
    logic [NUM_KEYS-1:0] w_press_evt, w_rel_evt;
    logic [NUM_KEYS-1:0] w_press_nxt, w_rel_nxt, w_level_nxt;
    logic [NUM_KEYS-1:0] r_key_level, r_key_press, r_key_release;
    logic                r_any, r_valid, w_valid_nxt;
    logic [c_code_w-1:0] r_code, w_code_nxt, w_code_raw;
    logic [c_code_w:0]   w_ones;

    // Buttons are inverted here so that 1 means held from the synchroniser on
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~n_key;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_state_t         r_state, w_state_nxt;
        logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
        logic               w_press, w_rel;

        always_ff @(posedge clock or negedge n_reset) begin
            if (!n_reset) begin
                r_state <= S_RELEASED;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_press     = 1'b0;
            w_rel       = 1'b0;
            case (r_state)
                S_RELEASED: begin
                    if (r_sync2[gi]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_state_nxt = S_PRESSED;
                            w_press     = 1'b1;
                        end else begin
                            w_state_nxt = S_PRESS_PEND;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                end
                S_PRESS_PEND: begin
                    if (!r_sync2[gi]) begin
                        w_state_nxt = S_RELEASED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_last) begin
                        w_state_nxt = S_PRESSED;
                        w_press     = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_cnt_one;
                    end
                end
                S_PRESSED: begin
                    if (!r_sync2[gi]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_state_nxt = S_RELEASED;
                            w_rel       = 1'b1;
                        end else begin
                            w_state_nxt = S_RELEASE_PEND;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                end
                default: begin
                    if (r_sync2[gi]) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_last) begin
                        w_state_nxt = S_RELEASED;
                        w_rel       = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_cnt_one;
                    end
                end
            endcase
        end

        assign w_press_evt[gi] = w_press;
        assign w_rel_evt[gi]   = w_rel;
    end

`ifdef KEY_CONDITIONER_LOCKOUT_EN
    logic [NUM_KEYS-1:0] r_mask, w_mask_nxt;
    logic                w_blocked;

    // Ascending scan grants the lowest committing index when nothing is held
    always_comb begin
        w_press_nxt = '0;
        w_rel_nxt   = '0;
        w_mask_nxt  = r_mask;
        w_blocked   = |r_key_level;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_press_evt[i]) begin
                if (w_blocked) begin
                    w_mask_nxt[i] = 1'b1;
                end else begin
                    w_press_nxt[i] = 1'b1;
                    w_blocked      = 1'b1;
                end
            end
            if (w_rel_evt[i]) begin
                if (r_mask[i]) w_mask_nxt[i] = 1'b0;
                else           w_rel_nxt[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) r_mask <= '0;
        else          r_mask <= w_mask_nxt;
    end
`else
    assign w_press_nxt = w_press_evt;
    assign w_rel_nxt   = w_rel_evt;
`endif

    assign w_level_nxt = (r_key_level | w_press_nxt) & ~w_rel_nxt;

    always_comb begin
        w_ones     = '0;
        w_code_raw = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_level_nxt[i]) begin
                w_ones     = w_ones + (c_code_w + 1)'(1);
                w_code_raw = c_code_w'(i);
            end
        end
        w_valid_nxt = (w_ones == (c_code_w + 1)'(1));
        w_code_nxt  = w_valid_nxt ? w_code_raw : '0;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_key_level   <= '0;
            r_key_press   <= '0;
            r_key_release <= '0;
            r_any         <= 1'b0;
            r_valid       <= 1'b0;
            r_code        <= '0;
        end else begin
            r_key_level   <= w_level_nxt;
            r_key_press   <= w_press_nxt;
            r_key_release <= w_rel_nxt;
            r_any         <= |w_level_nxt;
            r_valid       <= w_valid_nxt;
            r_code        <= w_code_nxt;
        end
    end

    assign keyLevel   = r_key_level;
    assign keyPress   = r_key_press;
    assign keyRelease = r_key_release;
    assign anyKey     = r_any;
    assign keyValid   = r_valid;
    assign keyCode    = r_code;

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_conditioner
// Description : Directed self-checking bench for key_conditioner (4 keys, 4-cycle debounce).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    logic       clock;
    logic       n_reset;
    logic [3:0] n_key;
    logic [3:0] keyLevel, keyPress, keyRelease;
    logic       anyKey, keyValid;
    logic [1:0] keyCode;

    int n_checks = 0;
    int n_pass   = 0;

    key_conditioner #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .n_key      (n_key),
        .keyLevel   (keyLevel),
        .keyPress   (keyPress),
        .keyRelease (keyRelease),
        .anyKey     (anyKey),
        .keyValid   (keyValid),
        .keyCode    (keyCode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Full output word: {level, press, release, any, valid, code}
    function automatic logic [15:0] outs();
        return {2'b00, keyLevel, keyPress, keyRelease, anyKey, keyValid, keyCode};
    endfunction

    initial begin
        n_reset = 1'b0;
        n_key   = 4'hF;

        // Reset and idle
        tick(3);
        check("reset_outs", outs(), 16'h0000);
        n_reset = 1'b1;
        tick(20);
        check("idle_outs", outs(), 16'h0000);

        // Clean press of key2
        n_key = 4'b1011;
        tick(5);
        check("press_e5_none", {keyLevel, keyPress}, 8'h00);
        tick(1);
        check("press_e6_pulse", keyPress, 4'b0100);
        check("press_e6_level", keyLevel, 4'b0100);
        check("press_e6_flags", {anyKey, keyValid, keyCode}, 4'b1110);
        tick(1);
        check("press_e7_pulse_end", {keyLevel, keyPress}, 8'h40);

        // Clean release of key2
        n_key = 4'hF;
        tick(5);
        check("rel_e5_none", {keyLevel, keyRelease}, 8'h40);
        tick(1);
        check("rel_e6_pulse", keyRelease, 4'b0100);
        check("rel_e6_outs", {keyLevel, anyKey, keyValid, keyCode}, 8'h00);
        tick(1);
        check("rel_e7_pulse_end", keyRelease, 4'b0000);

        // Bounce on key0: low 3, high 2, then low and held
        n_key = 4'b1110;
        tick(3);
        check("bounce_low_none", keyPress, 4'b0000);
        n_key = 4'hF;
        tick(1);
        check("bounce_high1_none", keyPress, 4'b0000);
        tick(1);
        check("bounce_high2_none", keyPress, 4'b0000);
        n_key = 4'b1110;
        tick(3);
        check("bounce_e3_none", {keyLevel, keyPress}, 8'h00);
        tick(2);
        check("bounce_e5_none", {keyLevel, keyPress}, 8'h00);
        tick(1);
        check("bounce_e6_pulse", {keyLevel, keyPress}, 8'h11);
        check("bounce_e6_code", {anyKey, keyValid, keyCode}, 4'b1100);
        n_key = 4'hF;
        tick(6);
        check("bounce_rel_pulse", {keyLevel, keyRelease}, 8'h01);
        tick(4);

`ifdef KEY_CONDITIONER_LOCKOUT_EN
        // Key1 held, key3 added later is masked
        n_key = 4'b1101;
        tick(6);
        check("lock_k1_press", {keyLevel, keyPress}, 8'h22);
        n_key = 4'b0101;
        tick(6);
        check("lock_k3_masked", {keyLevel, keyPress}, 8'h20);
        check("lock_k3_flags", {anyKey, keyValid, keyCode}, 4'b1101);
        n_key = 4'b1101;
        tick(6);
        check("lock_k3_no_rel", {keyLevel, keyRelease}, 8'h20);
        tick(1);
        check("lock_k3_no_rel2", keyRelease, 4'b0000);
        n_key = 4'hF;
        tick(6);
        check("lock_k1_rel", {keyLevel, keyRelease}, 8'h02);
        tick(4);
        // Same-edge key0 + key3 from idle
        n_key = 4'b0110;
        tick(6);
        check("lock_same_edge", {keyLevel, keyPress}, 8'h11);
        check("lock_same_flags", {anyKey, keyValid, keyCode}, 4'b1100);
        n_key = 4'hF;
        tick(6);
        check("lock_same_rel", {keyLevel, keyRelease}, 8'h01);
        tick(4);
`else
        // Simultaneous keys 0 and 3
        n_key = 4'b0110;
        tick(5);
        check("multi_e5_none", keyPress, 4'b0000);
        tick(1);
        check("multi_e6_pulse", {keyLevel, keyPress}, 8'h99);
        check("multi_e6_flags", {anyKey, keyValid, keyCode}, 4'b1000);
        n_key = 4'hF;
        tick(6);
        check("multi_rel", {keyLevel, keyRelease}, 8'h09);
        check("multi_rel_flags", {anyKey, keyValid, keyCode}, 4'b0000);
        tick(4);
`endif

        // Key1 held, then key2 added; reset lands mid-pending
        n_key = 4'b1101;
        tick(6);
        check("mid_k1_level", keyLevel, 4'b0010);
        n_key = 4'b1001;
        tick(4);
        n_reset = 1'b0;
        #1;
        check("mid_async_reset", outs(), 16'h0000);
        tick(1);
        check("mid_reset_hold", outs(), 16'h0000);
        n_reset = 1'b1;
        tick(5);
        check("mid_e5_none", {keyLevel, keyPress}, 8'h00);
        tick(1);
`ifdef KEY_CONDITIONER_LOCKOUT_EN
        check("mid_e6_pulse", {keyLevel, keyPress}, 8'h22);
`else
        check("mid_e6_pulse", {keyLevel, keyPress}, 8'h66);
        check("mid_e6_flags", {anyKey, keyValid, keyCode}, 4'b1000);
`endif
        tick(1);
        check("mid_e7_pulse_end", keyPress, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage that sits directly upstream of the colour-memory game controller. It takes the raw active-low push-buttons and synchronises and debounces each key. It then delivers clean, active-high key levels, single-cycle press and release pulses, and a one-key validity flag with an encoded index. The game FSM consumes `keyLevel`/`keyPress` instead of raw inverted `n_key`, which removes bounce-induced false presses and double state advances.

## Interface

Parameters:
- `NUM_KEYS`, 4: number of keys, minimum 2.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz), minimum 1.

Ports:
- `clock`, in, 1: single system clock; all logic on rising edge.
- `n_reset`, in, 1: asynchronous, active-low reset.
- `n_key`, in, NUM_KEYS: raw buttons, 0 = pressed; asynchronous to `clock`.
- `keyLevel`, out, NUM_KEYS: debounced level, 1 = held.
- `keyPress`, out, NUM_KEYS: one-cycle pulse per accepted press.
- `keyRelease`, out, NUM_KEYS: one-cycle pulse per accepted release.
- `anyKey`, out, 1: OR of `keyLevel`.
- `keyValid`, out, 1: exactly one `keyLevel` bit set.
- `keyCode`, out, $clog2(NUM_KEYS): index of the single held key when `keyValid`, else 0.

## Operation

- Each key uses a two-flop synchroniser on `~n_key[i]` (sync1 → sync2).
- Each key has its own FSM and counter, width $clog2(DEBOUNCE_CYCLES+1):
  - RELEASED: if sync2 = 1, go to PRESS_PENDING and set counter to 1. With DEBOUNCE_CYCLES = 1, commit immediately instead.
  - PRESS_PENDING: if sync2 = 0, go back to RELEASED and clear the counter; no output. Otherwise the counter increments. On the edge where the counter equals DEBOUNCE_CYCLES-1 and sync2 is still 1, commit: go to PRESSED, set `keyLevel[i]`=1, pulse `keyPress[i]`, clear the counter.
  - PRESSED / RELEASE_PENDING: mirror of the above for sync2 = 0. The commit sets `keyLevel[i]`=0 and pulses `keyRelease[i]`.
- A bounce shorter than DEBOUNCE_CYCLES cycles produces no output and restarts the count.
- `anyKey`, `keyValid` and `keyCode` are registered and computed from the next value of `keyLevel`, so they change on the same edge as `keyLevel`.
- When two or more keys are held: `keyValid`=0 and `keyCode`=0.
- Keys are fully independent: simultaneous commits on different keys all pulse on the same edge.
- Reset (`n_reset` low, asynchronous):
  - Sync flops reset to "released".
  - All FSMs go to RELEASED and all counters clear.
  - Every output goes to 0.
  - Reset in the middle of a pending state discards all progress.

## Timing

- Edge 1 is the first rising edge that samples a new, stable raw level.
- `keyLevel` and `keyPress`/`keyRelease` update on edge DEBOUNCE_CYCLES+2:
  - Edges 1–2 are synchroniser latency.
  - Edges 3..DEBOUNCE_CYCLES+2 are counting.
  - With DEBOUNCE_CYCLES=4 the update is on edge 6.
- Press and release pulses are exactly one cycle wide.
- A key can generate at most one press pulse before its next release pulse.
- Minimum period between a release pulse and the next press pulse on the same key is DEBOUNCE_CYCLES cycles.

## Configuration

- `KEY_CONDITIONER_LOCKOUT_EN` defined: first-key lockout.
  - A key that commits to PRESSED while any other key already has `keyLevel`=1 is masked.
  - A masked key's FSM still tracks the input, but its `keyLevel` bit stays 0, it produces no `keyPress`, and its later release produces no `keyRelease`.
  - If several keys commit on the same edge from the all-released state, only the lowest index is accepted.
  - `keyValid` is therefore 1 whenever `anyKey` is 1.
- Not defined: all keys are independent; no masking logic is synthesised.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and NUM_KEYS=4.

1. Reset: hold `n_reset`=0 with `n_key`=4'hF → all outputs 0. Release reset and idle 20 cycles → outputs stay 0.
2. Clean press: set `n_key`=4'b1011 and hold.
   - Edge 6 → `keyPress`=4'b0100 for one cycle.
   - `keyLevel`=4'b0100, `anyKey`=1, `keyValid`=1, `keyCode`=2.
   - `n_key`=4'hF held → on edge 6, `keyRelease`=4'b0100 pulse; `keyLevel`=0, `keyValid`=0.
3. Bounce rejection: key0 low for 3 cycles, then high for 2, then low for 10.
   - No pulse during the bounce.
   - `keyPress`=4'b0001 on the 6th edge after the final low begins.
4. Multi-key, macro off: `n_key`=4'b0110 applied on one edge.
   - Edge 6 → `keyPress`=4'b1001, `keyLevel`=4'b1001, `keyValid`=0, `keyCode`=0.
5. Lockout, macro on:
   - Key1 held, then key3 pressed → `keyLevel` stays 4'b0010 and there is no `keyPress` for key3.
   - Release key3 → no `keyRelease`.
   - Same-edge key0+key3 from idle → `keyLevel`=4'b0001, `keyCode`=0.
6. Mid-pending reset: key2 held; assert `n_reset` on edge 4.
   - All outputs 0 immediately.
   - Deassert with key still held → `keyPress`=4'b0100 arrives a full 6 edges after release.
